// File: rtl/irrigation_zone_scheduler.sv
// Round-robin multi-zone irrigation scheduler: timed runs, dry-tank pause, post-run cooldown.
// Optional manual stop input is enabled by defining MANUAL_STOP_EN.
module irrigation_zone_scheduler #(
  parameter int ZONES          = 4,
  parameter int TIMER_W        = 16,
  parameter int RUN_TICKS      = 1000,
  parameter int COOLDOWN_TICKS = 100,
  localparam int ZW            = (ZONES > 1) ? $clog2(ZONES) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             full_tank,
  input  logic             empty_tank,
  input  logic [ZONES-1:0] splinker_switch,
  input  logic [ZONES-1:0] dripper_switch,
`ifdef MANUAL_STOP_EN
  input  logic             stop,
`endif
  output logic [ZONES-1:0] splinker,
  output logic [ZONES-1:0] dripper,
  output logic [ZW-1:0]    active_zone,
  output logic             busy,
  output logic             done,
  output logic [ZONES-1:0] fault
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WATER    = 2'd1,
    ST_PAUSE    = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  state_t             state_r;
  logic [TIMER_W-1:0] timer_r;
  logic [ZW-1:0]      last_zone_r;
  logic [ZW-1:0]      zone_r;
  logic               mode_spl_r;

  logic [ZONES-1:0]   valid_s;
  logic               zone_valid_s;
  logic               stop_s;
  logic               pick_found_s;
  logic [ZW-1:0]      pick_zone_s;
  logic [ZW:0]        arb_sum_s;
  logic [ZW-1:0]      arb_idx_s;

  // One-hot valve vector for a zone, gated by the mode enable
  function automatic logic [ZONES-1:0] valve_decode(input logic [ZW-1:0] zone, input logic en);
    logic [ZONES-1:0] v;
    v = ZONES'(1'b1) << zone;
    return en ? v : {ZONES{1'b0}};
  endfunction

`ifdef MANUAL_STOP_EN
  assign stop_s = stop;
`else
  assign stop_s = 1'b0;
`endif

  assign valid_s      = splinker_switch ^ dripper_switch;
  assign zone_valid_s = valid_s[zone_r];

  // Round-robin search: first valid zone after the last one served, wrapping
  always_comb begin
    pick_found_s = 1'b0;
    pick_zone_s  = '0;
    arb_sum_s    = '0;
    arb_idx_s    = '0;
    for (int off = 1; off <= ZONES; off++) begin
      arb_sum_s = {1'b0, last_zone_r} + (ZW+1)'(off);
      if (arb_sum_s >= (ZW+1)'(ZONES)) begin
        arb_sum_s = arb_sum_s - (ZW+1)'(ZONES);
      end else begin
        arb_sum_s = arb_sum_s;
      end
      arb_idx_s = arb_sum_s[ZW-1:0];
      if (!pick_found_s && valid_s[arb_idx_s]) begin
        pick_found_s = 1'b1;
        pick_zone_s  = arb_idx_s;
      end else begin
        pick_found_s = pick_found_s;
      end
    end
  end

  // Scheduler FSM; valves and status are registered alongside the state they decode
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      timer_r     <= '0;
      last_zone_r <= ZW'(ZONES-1);
      zone_r      <= '0;
      mode_spl_r  <= 1'b0;
      splinker    <= '0;
      dripper     <= '0;
      active_zone <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fault       <= '0;
    end else begin
      done  <= 1'b0;
      fault <= splinker_switch & dripper_switch;
      case (state_r)
        ST_IDLE: begin
          splinker    <= '0;
          dripper     <= '0;
          busy        <= 1'b0;
          active_zone <= '0;
          if (!stop_s && full_tank && pick_found_s) begin
            state_r     <= ST_WATER;
            zone_r      <= pick_zone_s;
            mode_spl_r  <= splinker_switch[pick_zone_s];
            last_zone_r <= pick_zone_s;
            timer_r     <= TIMER_W'(RUN_TICKS);
            splinker    <= valve_decode(pick_zone_s, splinker_switch[pick_zone_s]);
            dripper     <= valve_decode(pick_zone_s, dripper_switch[pick_zone_s]);
            busy        <= 1'b1;
            active_zone <= pick_zone_s;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WATER: begin
          if (stop_s) begin
            state_r     <= ST_IDLE;
            timer_r     <= '0;
            splinker    <= '0;
            dripper     <= '0;
            busy        <= 1'b0;
            active_zone <= '0;
          end else if (!zone_valid_s) begin
            state_r  <= ST_COOLDOWN;
            timer_r  <= TIMER_W'(COOLDOWN_TICKS);
            splinker <= '0;
            dripper  <= '0;
          end else if (empty_tank) begin
            state_r  <= ST_PAUSE;
            splinker <= '0;
            dripper  <= '0;
          end else if (tick) begin
            if (timer_r == TIMER_W'(1)) begin
              done     <= 1'b1;
              state_r  <= ST_COOLDOWN;
              timer_r  <= TIMER_W'(COOLDOWN_TICKS);
              splinker <= '0;
              dripper  <= '0;
            end else begin
              timer_r <= timer_r - TIMER_W'(1);
            end
          end else begin
            state_r <= ST_WATER;
          end
        end
        ST_PAUSE: begin
          if (stop_s) begin
            state_r     <= ST_IDLE;
            timer_r     <= '0;
            splinker    <= '0;
            dripper     <= '0;
            busy        <= 1'b0;
            active_zone <= '0;
          end else if (!zone_valid_s) begin
            state_r <= ST_COOLDOWN;
            timer_r <= TIMER_W'(COOLDOWN_TICKS);
          end else if (full_tank && !empty_tank) begin
            state_r  <= ST_WATER;
            splinker <= valve_decode(zone_r, mode_spl_r);
            dripper  <= valve_decode(zone_r, !mode_spl_r);
          end else begin
            state_r <= ST_PAUSE;
          end
        end
        ST_COOLDOWN: begin
          splinker <= '0;
          dripper  <= '0;
          // Leaves on the tick that expires the count, so cooldown lasts exactly COOLDOWN_TICKS ticks
          if (stop_s || (timer_r == '0) || (tick && (timer_r == TIMER_W'(1)))) begin
            state_r     <= ST_IDLE;
            timer_r     <= '0;
            busy        <= 1'b0;
            active_zone <= '0;
          end else if (tick) begin
            timer_r <= timer_r - TIMER_W'(1);
          end else begin
            state_r <= ST_COOLDOWN;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          timer_r     <= '0;
          splinker    <= '0;
          dripper     <= '0;
          busy        <= 1'b0;
          active_zone <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// Directed self-checking bench for irrigation_zone_scheduler (ZONES=4, RUN=3, CD=2, tick every cycle).
module tb_irrigation_zone_scheduler;
  logic       clock = 1'b0;
  logic       reset;
  logic       tick;
  logic       full_tank;
  logic       empty_tank;
  logic [3:0] splinker_switch;
  logic [3:0] dripper_switch;
  logic       stop;
  logic [3:0] splinker;
  logic [3:0] dripper;
  logic [1:0] active_zone;
  logic       busy;
  logic       done;
  logic [3:0] fault;

  int checks = 0;
  int errors = 0;

  irrigation_zone_scheduler #(
    .ZONES(4), .TIMER_W(16), .RUN_TICKS(3), .COOLDOWN_TICKS(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .tick(tick),
    .full_tank(full_tank),
    .empty_tank(empty_tank),
    .splinker_switch(splinker_switch),
    .dripper_switch(dripper_switch),
`ifdef MANUAL_STOP_EN
    .stop(stop),
`endif
    .splinker(splinker),
    .dripper(dripper),
    .active_zone(active_zone),
    .busy(busy),
    .done(done),
    .fault(fault)
  );

  always #5 clock = ~clock;

  task automatic do_reset();
    reset = 1'b0;
    tick = 1'b1;
    full_tank = 1'b0;
    empty_tank = 1'b0;
    splinker_switch = 4'b0000;
    dripper_switch = 4'b0000;
    stop = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick = 1'b1;
    full_tank = 1'b1;
    empty_tank = 1'b0;
    splinker_switch = 4'b0000;
    dripper_switch = 4'b0000;
    stop = 1'b0;
    @(negedge clock);
    checks++; if (splinker !== 4'b0000) begin errors++; $display("FAIL reset_splinker got %b want 0000", splinker); end
    checks++; if (dripper !== 4'b0000) begin errors++; $display("FAIL reset_dripper got %b want 0000", dripper); end
    checks++; if (active_zone !== 2'd0) begin errors++; $display("FAIL reset_active got %0d want 0", active_zone); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (fault !== 4'b0000) begin errors++; $display("FAIL reset_fault got %b want 0000", fault); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_request_busy got %b want 0", busy); end
  endtask

  task automatic test_single_run();
    logic [3:0] exp_spl [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
    logic       exp_done [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       exp_busy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset();
    full_tank = 1'b1;
    splinker_switch = 4'b0001;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      checks++; if (splinker !== exp_spl[c]) begin errors++; $display("FAIL single_splinker cyc %0d got %b want %b", c, splinker, exp_spl[c]); end
      checks++; if (done !== exp_done[c]) begin errors++; $display("FAIL single_done cyc %0d got %b want %b", c, done, exp_done[c]); end
      checks++; if (busy !== exp_busy[c]) begin errors++; $display("FAIL single_busy cyc %0d got %b want %b", c, busy, exp_busy[c]); end
    end
    splinker_switch = 4'b0000;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_stays_idle got %b want 0", busy); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_az [3] = '{2'd0, 2'd1, 2'd2};
    logic [3:0] exp_s [3] = '{4'b0001, 4'b0000, 4'b0100};
    logic [3:0] exp_d [3] = '{4'b0000, 4'b0010, 4'b0000};
    int n;
    do_reset();
    full_tank = 1'b1;
    splinker_switch = 4'b0101;
    dripper_switch = 4'b0010;
    for (int r = 0; r < 3; r++) begin
      n = 0;
      do begin @(negedge clock); n++; end while (((splinker | dripper) == 4'b0000) && n < 20);
      checks++; if ((splinker | dripper) == 4'b0000) begin errors++; $display("FAIL rr_start_timeout run %0d got no valve want valve", r); end
      checks++; if (active_zone !== exp_az[r]) begin errors++; $display("FAIL rr_active run %0d got %0d want %0d", r, active_zone, exp_az[r]); end
      checks++; if (splinker !== exp_s[r]) begin errors++; $display("FAIL rr_splinker run %0d got %b want %b", r, splinker, exp_s[r]); end
      checks++; if (dripper !== exp_d[r]) begin errors++; $display("FAIL rr_dripper run %0d got %b want %b", r, dripper, exp_d[r]); end
      n = 0;
      do begin @(negedge clock); n++; end while (busy !== 1'b0 && n < 20);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rr_end_timeout run %0d got busy %b want 0", r, busy); end
    end
    splinker_switch = 4'b0000;
    dripper_switch = 4'b0000;
    @(negedge clock);
  endtask

  task automatic test_pause();
    int n;
    do_reset();
    full_tank = 1'b1;
    splinker_switch = 4'b0001;
    @(negedge clock);
    checks++; if (splinker !== 4'b0001) begin errors++; $display("FAIL pause_start got %b want 0001", splinker); end
    @(negedge clock);
    empty_tank = 1'b1;
    full_tank = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      checks++; if (splinker !== 4'b0000) begin errors++; $display("FAIL pause_valve cyc %0d got %b want 0000", c, splinker); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL pause_busy cyc %0d got %b want 1", c, busy); end
    end
    full_tank = 1'b1;
    empty_tank = 1'b0;
    @(negedge clock);
    checks++; if (splinker !== 4'b0001 || done !== 1'b0) begin errors++; $display("FAIL pause_resume got %b/%b want 0001/0", splinker, done); end
    @(negedge clock);
    checks++; if (splinker !== 4'b0001 || done !== 1'b0) begin errors++; $display("FAIL pause_tick2 got %b/%b want 0001/0", splinker, done); end
    @(negedge clock);
    checks++; if (splinker !== 4'b0000 || done !== 1'b1) begin errors++; $display("FAIL pause_done got %b/%b want 0000/1", splinker, done); end
    splinker_switch = 4'b0000;
    n = 0;
    do begin @(negedge clock); n++; end while (busy !== 1'b0 && n < 20);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL pause_end_timeout got busy %b want 0", busy); end
  endtask

  task automatic test_fault_abort();
    do_reset();
    full_tank = 1'b1;
    splinker_switch = 4'b1000;
    dripper_switch = 4'b1010;
    @(negedge clock);
    checks++; if (fault !== 4'b1000) begin errors++; $display("FAIL fault_reg got %b want 1000", fault); end
    checks++; if (dripper !== 4'b0010 || splinker !== 4'b0000) begin errors++; $display("FAIL fault_serve got s=%b d=%b want s=0000 d=0010", splinker, dripper); end
    checks++; if (active_zone !== 2'd1) begin errors++; $display("FAIL fault_active got %0d want 1", active_zone); end
    @(negedge clock);
    dripper_switch = 4'b1000;
    @(negedge clock);
    checks++; if (dripper !== 4'b0000 || done !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL abort got d=%b done=%b busy=%b want 0000/0/1", dripper, done, busy); end
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL abort_no_done cyc %0d got %b want 0", c, done); end
      checks++; if (splinker[3] !== 1'b0 || dripper[3] !== 1'b0) begin errors++; $display("FAIL zone3_watered cyc %0d got s=%b d=%b want bit3 0", c, splinker, dripper); end
      checks++; if (fault !== 4'b1000) begin errors++; $display("FAIL fault_hold cyc %0d got %b want 1000", c, fault); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got busy %b want 0", busy); end
    splinker_switch = 4'b0000;
    dripper_switch = 4'b0000;
  endtask

  task automatic test_async_reset();
    do_reset();
    full_tank = 1'b1;
    splinker_switch = 4'b0010;
    @(negedge clock);
    @(negedge clock);
    checks++; if (splinker !== 4'b0010) begin errors++; $display("FAIL areset_pre got %b want 0010", splinker); end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (splinker !== 4'b0000 || dripper !== 4'b0000) begin errors++; $display("FAIL areset_valves got s=%b d=%b want 0000", splinker, dripper); end
    checks++; if (busy !== 1'b0 || active_zone !== 2'd0 || done !== 1'b0) begin errors++; $display("FAIL areset_status got busy=%b az=%0d done=%b want 0/0/0", busy, active_zone, done); end
    @(negedge clock);
    splinker_switch = 4'b0000;
    reset = 1'b1;
  endtask

`ifdef MANUAL_STOP_EN
  task automatic test_stop();
    do_reset();
    full_tank = 1'b1;
    splinker_switch = 4'b0001;
    @(negedge clock);
    @(negedge clock);
    stop = 1'b1;
    @(negedge clock);
    checks++; if (splinker !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL stop_water got s=%b busy=%b done=%b want 0000/0/0", splinker, busy, done); end
    @(negedge clock);
    checks++; if (busy !== 1'b0 || splinker !== 4'b0000) begin errors++; $display("FAIL stop_blocks_arb got busy=%b s=%b want 0/0000", busy, splinker); end
    stop = 1'b0;
    splinker_switch = 4'b0000;
    @(negedge clock);
  endtask
`endif

  initial begin
    test_reset();
    test_single_run();
    test_round_robin();
    test_pause();
    test_fault_abort();
    test_async_reset();
`ifdef MANUAL_STOP_EN
    test_stop();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
